// File: rtl/vcve2_pkg.sv
// Shared vector-unit types and decode helpers for the VRF address generator.
package vcve2_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2,
    SEW64 = 3'd3
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL1     = 3'd0,
    LMUL2     = 3'd1,
    LMUL4     = 3'd2,
    LMUL8     = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL1_8   = 3'd5,
    LMUL1_4   = 3'd6,
    LMUL1_2   = 3'd7
  } vlmul_e;

  typedef enum logic [1:0] {
    AGU_IDLE = 2'd0,
    AGU_WALK = 2'd1,
    AGU_DONE = 2'd2
  } agu_state_e;

  // Unsupported widths fall back to a full word per element.
  function automatic logic [2:0] sew_to_bytes(vsew_e sew);
    case (sew)
      SEW8:    return 3'd1;
      SEW16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Fractional groups still occupy one whole register.
  function automatic logic [3:0] lmul_to_n(vlmul_e lmul);
    case (lmul)
      LMUL2:   return 4'd2;
      LMUL4:   return 4'd4;
      LMUL8:   return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/vcve2_vrf_agu_if.sv
// Request/response bundle between the VRF wrapper FSMs (master) and the AGU (slave).
interface vcve2_vrf_agu_if #(
  parameter int unsigned NumIfs = 1
);
  import vcve2_pkg::*;

  logic                     load_i;
  logic                     incr_i;
  logic [NumIfs-1:0]        get_rs1_i;
  logic [NumIfs-1:0]        get_rs2_i;
  logic [NumIfs-1:0]        get_rd_i;
  logic [4:0]               vs1_i;
  logic [4:0]               vs2_i;
  logic [4:0]               vd_i;
  vlmul_e                   lmul_i;
  vsew_e                    sew_i;
  logic [31:0]              vl_i;
  logic                     slide_op_i;
  logic                     is_slide_up_i;
  logic [31:0]              slide_offset_i;
  logic [NumIfs-1:0][31:0]  addr_o;
  logic [1:0]               slide_shift_o;
  logic [NumIfs-1:0]        oob_o;
  logic                     busy_o;
  logic                     last_o;
  logic                     done_o;

  modport master (
    output load_i, incr_i, get_rs1_i, get_rs2_i, get_rd_i, vs1_i, vs2_i, vd_i,
           lmul_i, sew_i, vl_i, slide_op_i, is_slide_up_i, slide_offset_i,
    input  addr_o, slide_shift_o, oob_o, busy_o, last_o, done_o
  );

  modport slave (
    input  load_i, incr_i, get_rs1_i, get_rs2_i, get_rd_i, vs1_i, vs2_i, vd_i,
           lmul_i, sew_i, vl_i, slide_op_i, is_slide_up_i, slide_offset_i,
    output addr_o, slide_shift_o, oob_o, busy_o, last_o, done_o
  );

endinterface

// File: rtl/vcve2_agu_port.sv
// One data-memory interface: picks the vs1/vs2/vd address and flags out-of-group slide sources.
module vcve2_agu_port (
  input  logic               i_get_rs1,
  input  logic               i_get_rs2,
  input  logic               i_get_rd,
  input  logic [31:0]        i_base1,
  input  logic [31:0]        i_base2,
  input  logic [31:0]        i_based,
  input  logic [31:0]        i_byte_off,
  input  logic signed [36:0] i_src_off,
  input  logic signed [36:0] i_group_bytes,
  output logic [31:0]        o_addr,
  output logic               o_oob
);

  always_comb begin
    o_addr = '0;
    if (i_get_rd)       o_addr = i_based + i_byte_off;
    else if (i_get_rs2) o_addr = i_base2 + i_src_off[31:0];
    else if (i_get_rs1) o_addr = i_base1 + i_byte_off;
  end

  assign o_oob = i_get_rs2 & (i_src_off[36] | (i_src_off >= i_group_bytes));

endmodule

// File: rtl/vcve2_vrf_agu.sv
// VRF address generator: latches operands on load, walks the register group one word per incr.
module vcve2_vrf_agu
  import vcve2_pkg::*;
#(
  parameter int unsigned NumIfs        = 1,
  parameter int unsigned VLEN          = 128,
  parameter logic [31:0] VRF_BASE_ADDR = 32'h0001_0000
) (
  input logic           clk_i,
  input logic           rst_ni,
  vcve2_vrf_agu_if.slave bus
);

  localparam logic [31:0] VlenBytes = 32'(VLEN / 8);
  localparam logic [31:0] VlenWords = 32'(VLEN / 32);

  function automatic logic [31:0] reg_base(logic [4:0] r);
    return VRF_BASE_ADDR + 32'(r) * VlenBytes;
  endfunction

  agu_state_e  r_state, w_state_nxt;
  logic [31:0] r_word_cnt, w_cnt_nxt;
  logic [31:0] r_total_words, r_group_words;
  logic [31:0] r_base1, r_base2, r_based;
  logic        r_slide_op, r_slide_up;
  logic [34:0] r_slide_sh;
  logic [1:0]  r_slide_shift;

  logic [2:0]  w_sew_bytes;
  logic [31:0] w_group_words;
  logic [34:0] w_vl_bytes, w_vl_words, w_slide_bytes;
  logic [31:0] w_total_words;
  logic        w_last;

  // Operand decode, evaluated on the load cycle from the raw inputs
  assign w_sew_bytes   = sew_to_bytes(bus.sew_i);
  assign w_group_words = 32'(lmul_to_n(bus.lmul_i)) * VlenWords;
  assign w_vl_bytes    = 35'(bus.vl_i) * 35'(w_sew_bytes);
  assign w_vl_words    = (w_vl_bytes + 35'd3) >> 2;
  assign w_total_words = (w_vl_words > 35'(w_group_words)) ? w_group_words : w_vl_words[31:0];
  assign w_slide_bytes = 35'(bus.slide_offset_i) * 35'(w_sew_bytes);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_total_words <= '0;
      r_group_words <= '0;
      r_base1       <= '0;
      r_base2       <= '0;
      r_based       <= '0;
      r_slide_op    <= 1'b0;
      r_slide_up    <= 1'b0;
      r_slide_sh    <= '0;
      r_slide_shift <= '0;
    end else if (bus.load_i) begin
      r_total_words <= w_total_words;
      r_group_words <= w_group_words;
      r_base1       <= reg_base(bus.vs1_i);
      r_base2       <= reg_base(bus.vs2_i);
      r_based       <= reg_base(bus.vd_i);
      r_slide_op    <= bus.slide_op_i;
      r_slide_up    <= bus.is_slide_up_i;
      r_slide_sh    <= {w_slide_bytes[34:2], 2'b00};
      r_slide_shift <= w_slide_bytes[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= AGU_IDLE;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_cnt_nxt;
    end
  end

  assign w_last = (r_state == AGU_WALK) && (r_word_cnt == r_total_words - 32'd1);

  // A fresh load always wins, even over an incr in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_word_cnt;
    if (bus.load_i) begin
      w_cnt_nxt   = '0;
      w_state_nxt = (w_total_words == 32'd0) ? AGU_DONE : AGU_WALK;
    end else begin
      case (r_state)
        AGU_WALK: begin
          if (bus.incr_i) begin
            if (w_last) w_state_nxt = AGU_DONE;
            else        w_cnt_nxt   = r_word_cnt + 32'd1;
          end
        end
        AGU_DONE: w_state_nxt = AGU_IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  logic [31:0]        w_byte_off;
  logic signed [36:0] w_boff_s, w_sh_s, w_src_off, w_group_bytes;

  assign w_byte_off    = {r_word_cnt[29:0], 2'b00};
  assign w_boff_s      = $signed({5'b0, w_byte_off});
  assign w_sh_s        = $signed({2'b0, r_slide_sh});
  assign w_group_bytes = $signed({3'b0, r_group_words, 2'b00});

  // Slide sources are offset by whole words; the sub-word remainder leaves via slide_shift_o
  always_comb begin
    w_src_off = w_boff_s;
    if (r_slide_op) w_src_off = r_slide_up ? (w_boff_s - w_sh_s) : (w_boff_s + w_sh_s);
  end

  logic [NumIfs-1:0][31:0] w_addr;
  logic [NumIfs-1:0]       w_oob;

  for (genvar g = 0; g < NumIfs; g++) begin : g_port
    vcve2_agu_port u_port (
      .i_get_rs1     (bus.get_rs1_i[g]),
      .i_get_rs2     (bus.get_rs2_i[g]),
      .i_get_rd      (bus.get_rd_i[g]),
      .i_base1       (r_base1),
      .i_base2       (r_base2),
      .i_based       (r_based),
      .i_byte_off    (w_byte_off),
      .i_src_off     (w_src_off),
      .i_group_bytes (w_group_bytes),
      .o_addr        (w_addr[g]),
      .o_oob         (w_oob[g])
    );
  end

  assign bus.addr_o        = w_addr;
  assign bus.oob_o         = w_oob;
  assign bus.slide_shift_o = r_slide_shift;
  assign bus.busy_o        = (r_state == AGU_WALK);
  assign bus.last_o        = w_last;
  assign bus.done_o        = (r_state == AGU_DONE);

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Directed bench for vcve2_vrf_agu: one single-port and one three-port instance.
module tb_vcve2_vrf_agu;
  import vcve2_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vcve2_vrf_agu_if #(.NumIfs(1)) b1 ();
  vcve2_vrf_agu_if #(.NumIfs(3)) b3 ();

  vcve2_vrf_agu #(.NumIfs(1), .VLEN(128), .VRF_BASE_ADDR(32'h0001_0000)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
  vcve2_vrf_agu #(.NumIfs(3), .VLEN(128), .VRF_BASE_ADDR(32'h0001_0000)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b3.slave));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.load_i = 0; b1.incr_i = 0; b1.get_rs1_i = '0; b1.get_rs2_i = '0; b1.get_rd_i = '0;
    b1.vs1_i = 0; b1.vs2_i = 0; b1.vd_i = 0; b1.lmul_i = LMUL1; b1.sew_i = SEW8;
    b1.vl_i = 0; b1.slide_op_i = 0; b1.is_slide_up_i = 0; b1.slide_offset_i = 0;
    b3.load_i = 0; b3.incr_i = 0; b3.get_rs1_i = '0; b3.get_rs2_i = '0; b3.get_rd_i = '0;
    b3.vs1_i = 0; b3.vs2_i = 0; b3.vd_i = 0; b3.lmul_i = LMUL1; b3.sew_i = SEW8;
    b3.vl_i = 0; b3.slide_op_i = 0; b3.is_slide_up_i = 0; b3.slide_offset_i = 0;
  endtask

  task automatic load1(input logic [4:0] vs1, input logic [4:0] vs2, input vlmul_e lmul,
                       input vsew_e sew, input logic [31:0] vl, input logic slide,
                       input logic up, input logic [31:0] off);
    b1.vs1_i = vs1; b1.vs2_i = vs2; b1.vd_i = 5'd0; b1.lmul_i = lmul; b1.sew_i = sew;
    b1.vl_i = vl; b1.slide_op_i = slide; b1.is_slide_up_i = up; b1.slide_offset_i = off;
    b1.load_i = 1;
    cyc();
    b1.load_i = 0;
    #1;
  endtask

  task automatic incr1(input int n);
    for (int i = 0; i < n; i++) begin
      b1.incr_i = 1;
      cyc();
    end
    b1.incr_i = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #12;
    checks++;
    if ({b1.busy_o, b1.last_o, b1.done_o, b1.oob_o, b1.slide_shift_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
                         {b1.busy_o, b1.last_o, b1.done_o, b1.oob_o, b1.slide_shift_o});
    end
    @(negedge clk) rst_n = 1;
    b1.get_rs1_i = 1'b1;
    load1(5'd2, 5'd0, LMUL1, SEW32, 32'd4, 0, 0, 0);
    incr1(2);
    checks++;
    if (b1.addr_o[0] !== 32'h0001_0028 || b1.busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_pre_walk addr %h busy %b exp 00010028 1", b1.addr_o[0], b1.busy_o);
    end
    rst_n = 0;
    #1;
    checks++;
    if (b1.addr_o[0] !== 32'h0 || b1.busy_o !== 1'b0 || b1.last_o !== 1'b0 || b1.done_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_walk addr %h busy %b last %b done %b exp all 0",
                         b1.addr_o[0], b1.busy_o, b1.last_o, b1.done_o);
    end
    cyc();
    rst_n = 1;
    cyc();
    checks++;
    if (b1.busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy_after got %b exp 0", b1.busy_o);
    end
  endtask

  task automatic test_walk();
    b1.get_rs1_i = 1'b1;
    load1(5'd2, 5'd0, LMUL1, SEW32, 32'd4, 0, 0, 0);
    checks++;
    if (b1.addr_o[0] !== 32'h0001_0020 || b1.busy_o !== 1'b1 || b1.last_o !== 1'b0) begin
      errors++; $display("FAIL walk_w0 addr %h busy %b last %b exp 00010020 1 0",
                         b1.addr_o[0], b1.busy_o, b1.last_o);
    end
    incr1(3);
    checks++;
    if (b1.addr_o[0] !== 32'h0001_002C || b1.last_o !== 1'b1) begin
      errors++; $display("FAIL walk_w3 addr %h last %b exp 0001002c 1", b1.addr_o[0], b1.last_o);
    end
    incr1(1);
    checks++;
    if (b1.done_o !== 1'b1 || b1.busy_o !== 1'b0) begin
      errors++; $display("FAIL walk_done done %b busy %b exp 1 0", b1.done_o, b1.busy_o);
    end
    cyc();
    checks++;
    if (b1.done_o !== 1'b0 || b1.busy_o !== 1'b0) begin
      errors++; $display("FAIL walk_idle done %b busy %b exp 0 0", b1.done_o, b1.busy_o);
    end
    b1.incr_i = 1;
    cyc(); cyc();
    b1.incr_i = 0;
    checks++;
    if (b1.busy_o !== 1'b0 || b1.done_o !== 1'b0) begin
      errors++; $display("FAIL idle_incr busy %b done %b exp 0 0", b1.busy_o, b1.done_o);
    end
  endtask

  task automatic test_total_words();
    b1.get_rs1_i = 1'b1;
    load1(5'd2, 5'd0, LMUL1, SEW8, 32'd5, 0, 0, 0);
    checks++;
    if (b1.last_o !== 1'b0) begin
      errors++; $display("FAIL sew8_w0_last got %b exp 0", b1.last_o);
    end
    incr1(1);
    checks++;
    if (b1.last_o !== 1'b1 || b1.addr_o[0] !== 32'h0001_0024) begin
      errors++; $display("FAIL sew8_w1 last %b addr %h exp 1 00010024", b1.last_o, b1.addr_o[0]);
    end
    load1(5'd2, 5'd0, LMUL2, SEW32, 32'd100, 0, 0, 0);
    incr1(6);
    checks++;
    if (b1.last_o !== 1'b0 || b1.addr_o[0] !== 32'h0001_0038) begin
      errors++; $display("FAIL clamp_w6 last %b addr %h exp 0 00010038", b1.last_o, b1.addr_o[0]);
    end
    incr1(1);
    checks++;
    if (b1.last_o !== 1'b1 || b1.addr_o[0] !== 32'h0001_003C) begin
      errors++; $display("FAIL clamp_w7 last %b addr %h exp 1 0001003c", b1.last_o, b1.addr_o[0]);
    end
    incr1(1);
    checks++;
    if (b1.done_o !== 1'b1) begin
      errors++; $display("FAIL clamp_done got %b exp 1", b1.done_o);
    end
    cyc();
  endtask

  task automatic test_vl_zero();
    load1(5'd1, 5'd0, LMUL1, SEW32, 32'd0, 0, 0, 0);
    checks++;
    if (b1.done_o !== 1'b1 || b1.busy_o !== 1'b0) begin
      errors++; $display("FAIL vl0_done done %b busy %b exp 1 0", b1.done_o, b1.busy_o);
    end
    b1.incr_i = 1;
    cyc();
    checks++;
    if (b1.done_o !== 1'b0 || b1.busy_o !== 1'b0) begin
      errors++; $display("FAIL vl0_after done %b busy %b exp 0 0", b1.done_o, b1.busy_o);
    end
    b1.incr_i = 0;
  endtask

  task automatic test_slide();
    b1.get_rs1_i = 1'b0;
    b1.get_rs2_i = 1'b1;
    load1(5'd0, 5'd4, LMUL1, SEW16, 32'd8, 1, 0, 32'd3);
    checks++;
    if (b1.addr_o[0] !== 32'h0001_0044 || b1.slide_shift_o !== 2'd2 || b1.oob_o[0] !== 1'b0) begin
      errors++; $display("FAIL slidedown_w0 addr %h shift %0d oob %b exp 00010044 2 0",
                         b1.addr_o[0], b1.slide_shift_o, b1.oob_o[0]);
    end
    incr1(3);
    checks++;
    if (b1.oob_o[0] !== 1'b1) begin
      errors++; $display("FAIL slidedown_w3_oob got %b exp 1", b1.oob_o[0]);
    end
    load1(5'd0, 5'd4, LMUL2, SEW32, 32'd8, 1, 1, 32'd4);
    checks++;
    if (b1.oob_o[0] !== 1'b1 || b1.slide_shift_o !== 2'd0) begin
      errors++; $display("FAIL slideup_w0 oob %b shift %0d exp 1 0", b1.oob_o[0], b1.slide_shift_o);
    end
    incr1(4);
    checks++;
    if (b1.addr_o[0] !== 32'h0001_0040 || b1.oob_o[0] !== 1'b0) begin
      errors++; $display("FAIL slideup_w4 addr %h oob %b exp 00010040 0", b1.addr_o[0], b1.oob_o[0]);
    end
    b1.get_rs2_i = 1'b0;
    #1;
    checks++;
    if (b1.oob_o[0] !== 1'b0 || b1.addr_o[0] !== 32'h0) begin
      errors++; $display("FAIL nosel oob %b addr %h exp 0 00000000", b1.oob_o[0], b1.addr_o[0]);
    end
  endtask

  task automatic test_multi_port();
    b3.vs1_i = 5'd1; b3.vs2_i = 5'd2; b3.vd_i = 5'd3;
    b3.lmul_i = LMUL1; b3.sew_i = SEW32; b3.vl_i = 32'd4;
    b3.get_rs1_i = 3'b001; b3.get_rs2_i = 3'b010; b3.get_rd_i = 3'b100;
    b3.load_i = 1;
    cyc();
    b3.load_i = 0;
    #1;
    checks++;
    if (b3.addr_o !== {32'h0001_0030, 32'h0001_0020, 32'h0001_0010}) begin
      errors++; $display("FAIL multi_w0 got %h exp 000100300001002000010010", b3.addr_o);
    end
    b3.incr_i = 1;
    cyc();
    b3.incr_i = 0;
    #1;
    checks++;
    if (b3.addr_o !== {32'h0001_0034, 32'h0001_0024, 32'h0001_0014}) begin
      errors++; $display("FAIL multi_w1 got %h exp 000100340001002400010014", b3.addr_o);
    end
    b3.load_i = 1; b3.incr_i = 1;
    cyc();
    b3.load_i = 0; b3.incr_i = 0;
    #1;
    checks++;
    if (b3.addr_o[0] !== 32'h0001_0010 || b3.busy_o !== 1'b1) begin
      errors++; $display("FAIL load_beats_incr addr %h busy %b exp 00010010 1", b3.addr_o[0], b3.busy_o);
    end
    b3.get_rs1_i = 3'b111; b3.get_rs2_i = 3'b011; b3.get_rd_i = 3'b001;
    #1;
    checks++;
    if (b3.addr_o !== {32'h0001_0010, 32'h0001_0020, 32'h0001_0030}) begin
      errors++; $display("FAIL multi_priority got %h exp 000100100001002000010030", b3.addr_o);
    end
    b3.get_rs1_i = '0; b3.get_rs2_i = '0; b3.get_rd_i = '0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_total_words();
    test_vl_zero();
    test_slide();
    test_multi_port();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
